iob_cache_axi_mem: RTL and testbench
====================================

Name: iob_cache_axi_mem

Overview:
- AXI4 slave memory model that responds to the cache's AXI4 master back-end.
  - Accepts INCR bursts on the read channel (line replacement) and the write channel (write-through words or write-back lines).
  - Data is held in an internal word array.
- Used as the system-side target in cache testbenches and as a small on-chip backing memory in SoC builds.
- Read and write channels run independently, one outstanding transaction per channel.

Parameters:
AXI_ADDR_W, 32, byte address width of axi_araddr/axi_awaddr
AXI_DATA_W, 32, data bus width; equals cache BE_DATA_W
AXI_ID_W, 1, ID width
AXI_LEN_W, 8, burst length field width
MEM_ADDR_W, 12, log2 of array depth in AXI_DATA_W words

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
axi_awid  in  AXI_ID_W  write ID
axi_awaddr  in  AXI_ADDR_W  write byte address
axi_awlen  in  AXI_LEN_W  beats-1
axi_awsize, axi_awburst, axi_awlock, axi_awcache, axi_awprot, axi_awqos  in  3,2,1,4,3,4  accepted, ignored
axi_awvalid  in  1;  axi_awready  out  1
axi_wdata  in  AXI_DATA_W;  axi_wstrb  in  AXI_DATA_W/8;  axi_wlast  in  1
axi_wvalid  in  1;  axi_wready  out  1
axi_bid  out  AXI_ID_W;  axi_bresp  out  2;  axi_bvalid  out  1;  axi_bready  in  1
axi_arid  in  AXI_ID_W;  axi_araddr  in  AXI_ADDR_W;  axi_arlen  in  AXI_LEN_W
axi_arsize, axi_arburst, axi_arlock, axi_arcache, axi_arprot, axi_arqos  in  3,2,1,4,3,4  ignored
axi_arvalid  in  1;  axi_arready  out  1
axi_rid  out  AXI_ID_W;  axi_rdata  out  AXI_DATA_W;  axi_rresp  out  2;  axi_rlast  out  1
axi_rvalid  out  1;  axi_rready  in  1

Behaviour:
- Reset (rst=0, async):
  - Write FSM to W_IDLE, read FSM to R_IDLE.
  - awready=1, arready=1; wready, bvalid, rvalid, rlast = 0; rdata, rid, bid = 0.
  - Array contents are not reset.
  - Reset mid-burst aborts the burst; beats already written stay in the array.
- Addressing:
  - Word index = addr[MEM_ADDR_W+log2(AXI_DATA_W/8)-1 : log2(AXI_DATA_W/8)]; upper bits are dropped, so accesses wrap modulo array size.
  - Each beat increments the index by 1, wrapping from 2^MEM_ADDR_W-1 to 0.
  - Size and burst type are ignored: full-width INCR is always performed.
- Responses: bresp and rresp are always 00 (OKAY); bid and rid echo the captured awid and arid.
- Write FSM:
  - W_IDLE: awready=1. On awvalid, latch id, index and len into beat counter; awready→0; go to W_DATA next cycle.
  - W_DATA: wready=1. Each wvalid&wready writes the bytes enabled by wstrb at the current index, increments the index and decrements the counter.
  - Burst end: the beat with counter==0 ends the burst → W_RESP. wlast is not used for termination. If wlast disagrees with the counter, the response is still OKAY and an internal flag is raised for assertions.
  - W_RESP: bvalid=1 until bready, then W_IDLE with awready=1 in the following cycle.
  - Minimum single-beat write: AW handshake in cycle 0, W in cycle 1, bvalid in cycle 2.
  - W beats offered before AW are stalled (wready=0).
- Read FSM:
  - R_IDLE: arready=1. On arvalid, latch id, index and len; register rdata=mem[index]; rvalid=1 in the next cycle (latency 1); rlast=(len==0).
  - R_DATA: on rvalid&rready with counter≠0, load the next word and hold rvalid=1, giving back-to-back beats.
  - The last beat (rlast=1) handshakes → rvalid=0, return to R_IDLE; arready rises next cycle.
  - rdata, rlast and rid stay stable while rvalid&!rready.
- Simultaneous read and write:
  - Both FSMs proceed in the same cycle.
  - Same-index collision: read-before-write. The rdata load sees the old word; the new word is visible to the next load.
- Burst length: up to 2^AXI_LEN_W beats. A full 256-beat burst wraps the counter correctly.

Decomposition:
- Shared package/header holds the FSM state encodings, the AXI burst/resp constants (INCR=01, OKAY=00) and the byte-offset width macro.
- One natural sub-module: iob_cache_axi_mem_ram, a simple dual-port array with per-byte write enable and a registered read port.

Test Plan:
- Reset release → awready=1, arready=1, bvalid=0, rvalid=0.
- AW addr 0x10, len 3; W data 0xA..0xD, wstrb F → bvalid after 4th beat, bresp 00, bid=awid. Then AR 0x10 len 3 → rdata 0xA,0xB,0xC,0xD, rlast on 4th beat only.
- Write 0xFFFFFFFF to 0x20, then wstrb 0x2 with data 0x00001200 → read 0x20 returns 0xFFFF12FF.
- AR len 7 with rready toggled 1,0,0,1,… → each rdata held stable across stalls, 8 beats in order, arready low until last handshake.
- Write burst starting at the last word, len 1 → second beat lands at index 0, verified by readback.
- Concurrent AR and AW to the same address in the same cycle → read returns the old value; a subsequent read returns the new value.

Source files
------------

// File: rtl/iob_cache_axi_mem_pkg.sv
// Shared definitions for the AXI4 slave memory model: FSM encodings,
// AXI constants and the byte-offset width helper.
package iob_cache_axi_mem_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Number of address bits that select a byte inside one data word
    function automatic int byte_off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/iob_cache_axi_mem_ram.sv
// Simple dual-port word array: byte-enabled write port, registered read port.
// A read and a write to the same word in one cycle return the old contents.
module iob_cache_axi_mem_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W/8-1:0]   we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        for (int b = 0; b < DATA_W / 8; b++) begin
            if (we[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/iob_cache_axi_mem.sv
// AXI4 slave memory model: independent read and write burst FSMs in front of
// a word array; INCR full-width bursts, always OKAY responses.
module iob_cache_axi_mem
    import iob_cache_axi_mem_pkg::*;
#(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_ID_W   = 1,
    parameter int AXI_LEN_W  = 8,
    parameter int MEM_ADDR_W = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [AXI_ID_W-1:0]     axi_awid,
    input  logic [AXI_ADDR_W-1:0]   axi_awaddr,
    input  logic [AXI_LEN_W-1:0]    axi_awlen,
    input  logic [2:0]              axi_awsize,
    input  logic [1:0]              axi_awburst,
    input  logic                    axi_awlock,
    input  logic [3:0]              axi_awcache,
    input  logic [2:0]              axi_awprot,
    input  logic [3:0]              axi_awqos,
    input  logic                    axi_awvalid,
    output logic                    axi_awready,
    input  logic [AXI_DATA_W-1:0]   axi_wdata,
    input  logic [AXI_DATA_W/8-1:0] axi_wstrb,
    input  logic                    axi_wlast,
    input  logic                    axi_wvalid,
    output logic                    axi_wready,
    output logic [AXI_ID_W-1:0]     axi_bid,
    output logic [1:0]              axi_bresp,
    output logic                    axi_bvalid,
    input  logic                    axi_bready,
    input  logic [AXI_ID_W-1:0]     axi_arid,
    input  logic [AXI_ADDR_W-1:0]   axi_araddr,
    input  logic [AXI_LEN_W-1:0]    axi_arlen,
    input  logic [2:0]              axi_arsize,
    input  logic [1:0]              axi_arburst,
    input  logic                    axi_arlock,
    input  logic [3:0]              axi_arcache,
    input  logic [2:0]              axi_arprot,
    input  logic [3:0]              axi_arqos,
    input  logic                    axi_arvalid,
    output logic                    axi_arready,
    output logic [AXI_ID_W-1:0]     axi_rid,
    output logic [AXI_DATA_W-1:0]   axi_rdata,
    output logic [1:0]              axi_rresp,
    output logic                    axi_rlast,
    output logic                    axi_rvalid,
    input  logic                    axi_rready
);

    localparam int OFF_W = byte_off_w(AXI_DATA_W);

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [MEM_ADDR_W-1:0] aw_idx, ar_idx, w_idx, r_idx, r_raddr;
    logic [AXI_LEN_W-1:0]  w_cnt, r_cnt;
    logic                  w_beat, r_load, wlast_mismatch;

    // Upper address bits are dropped so accesses wrap modulo the array size
    assign aw_idx = axi_awaddr[MEM_ADDR_W+OFF_W-1:OFF_W];
    assign ar_idx = axi_araddr[MEM_ADDR_W+OFF_W-1:OFF_W];

    assign axi_bresp = AXI_RESP_OKAY;
    assign axi_rresp = AXI_RESP_OKAY;

    always_comb begin
        w_next      = w_state;
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        axi_bvalid  = 1'b0;
        w_beat      = 1'b0;
        case (w_state)
            W_IDLE: begin
                axi_awready = 1'b1;
                if (axi_awvalid) w_next = W_DATA;
            end
            W_DATA: begin
                axi_wready = 1'b1;
                if (axi_wvalid) begin
                    w_beat = 1'b1;
                    // The beat counter, not wlast, terminates the burst
                    if (w_cnt == '0) w_next = W_RESP;
                end
            end
            W_RESP: begin
                axi_bvalid = 1'b1;
                if (axi_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state        <= W_IDLE;
            axi_bid        <= '0;
            wlast_mismatch <= 1'b0;
        end else begin
            w_state <= w_next;
            if (w_state == W_IDLE && axi_awvalid) axi_bid <= axi_awid;
            if (w_beat) wlast_mismatch <= (axi_wlast != (w_cnt == '0));
        end
    end

    always_ff @(posedge clk) begin
        if (w_state == W_IDLE && axi_awvalid) begin
            w_idx <= aw_idx;
            w_cnt <= axi_awlen;
        end else if (w_beat) begin
            w_idx <= w_idx + 1'b1;
            w_cnt <= w_cnt - 1'b1;
        end
    end

    always_comb begin
        r_next      = r_state;
        axi_arready = 1'b0;
        axi_rvalid  = 1'b0;
        r_load      = 1'b0;
        r_raddr     = r_idx;
        case (r_state)
            R_IDLE: begin
                axi_arready = 1'b1;
                if (axi_arvalid) begin
                    r_load  = 1'b1;
                    r_raddr = ar_idx;
                    r_next  = R_DATA;
                end
            end
            R_DATA: begin
                axi_rvalid = 1'b1;
                if (axi_rready) begin
                    if (axi_rlast) r_next = R_IDLE;
                    else           r_load = 1'b1;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    // r_cnt holds the beats still to come after the one currently presented
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= R_IDLE;
            axi_rid   <= '0;
            axi_rlast <= 1'b0;
        end else begin
            r_state <= r_next;
            if (r_state == R_IDLE && axi_arvalid) begin
                axi_rid   <= axi_arid;
                axi_rlast <= (axi_arlen == '0);
            end else if (r_state == R_DATA && axi_rready) begin
                axi_rlast <= !axi_rlast && (r_cnt == AXI_LEN_W'(1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == R_IDLE && axi_arvalid) begin
            r_idx <= ar_idx + 1'b1;
            r_cnt <= axi_arlen;
        end else if (r_state == R_DATA && axi_rready && !axi_rlast) begin
            r_idx <= r_idx + 1'b1;
            r_cnt <= r_cnt - 1'b1;
        end
    end

    iob_cache_axi_mem_ram #(
        .DATA_W (AXI_DATA_W),
        .ADDR_W (MEM_ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (w_beat ? axi_wstrb : '0),
        .waddr (w_idx),
        .wdata (axi_wdata),
        .re    (r_load),
        .raddr (r_raddr),
        .rdata (axi_rdata)
    );

    logic unused_inputs;
    assign unused_inputs = ^{axi_awsize, axi_awburst ^ AXI_BURST_INCR, axi_awlock,
                             axi_awcache, axi_awprot, axi_awqos, axi_awaddr,
                             axi_arsize, axi_arburst, axi_arlock, axi_arcache,
                             axi_arprot, axi_arqos, axi_araddr, wlast_mismatch};

endmodule

// File: tb/tb_iob_cache_axi_mem.sv
// Bench for iob_cache_axi_mem: vector table plus burst sequences, read data
// checked through a scoreboard queue filled when each AR is issued.
module tb_iob_cache_axi_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [0:0]  axi_awid = '0;
    logic [31:0] axi_awaddr = '0;
    logic [7:0]  axi_awlen = '0;
    logic        axi_awvalid = 1'b0;
    logic        axi_awready;
    logic [31:0] axi_wdata = '0;
    logic [3:0]  axi_wstrb = '0;
    logic        axi_wlast = 1'b0;
    logic        axi_wvalid = 1'b0;
    logic        axi_wready;
    logic [0:0]  axi_bid;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready = 1'b0;
    logic [0:0]  axi_arid = '0;
    logic [31:0] axi_araddr = '0;
    logic [7:0]  axi_arlen = '0;
    logic        axi_arvalid = 1'b0;
    logic        axi_arready;
    logic [0:0]  axi_rid;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rlast;
    logic        axi_rvalid;
    logic        axi_rready = 1'b0;

    always #5 clk = ~clk;

    iob_cache_axi_mem dut (
        .clk(clk), .rst(rst),
        .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_awsize(3'd2), .axi_awburst(2'b01), .axi_awlock(1'b0),
        .axi_awcache(4'd0), .axi_awprot(3'd0), .axi_awqos(4'd0),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
        .axi_bready(axi_bready),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arsize(3'd2), .axi_arburst(2'b01), .axi_arlock(1'b0),
        .axi_arcache(4'd0), .axi_arprot(3'd0), .axi_arqos(4'd0),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
    } rexp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp;
    } vec_t;

    rexp_t       sb[$];
    logic [31:0] model [0:4095];
    logic [0:0]  exp_rid;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got no handshake, expected one within the cycle budget", name);
    endtask

    task automatic aw_xfer(input logic [0:0] id, input logic [31:0] addr, input logic [7:0] len);
        int n;
        n = 0;
        axi_awid = id; axi_awaddr = addr; axi_awlen = len; axi_awvalid = 1'b1;
        @(negedge clk);
        while (!axi_awready && n < 100) begin @(negedge clk); n++; end
        if (!axi_awready) fail_timeout("aw_timeout");
        @(posedge clk); #1;
        axi_awvalid = 1'b0;
    endtask

    task automatic ar_xfer(input logic [0:0] id, input logic [31:0] addr, input logic [7:0] len);
        int n;
        n = 0;
        exp_rid = id;
        axi_arid = id; axi_araddr = addr; axi_arlen = len; axi_arvalid = 1'b1;
        @(negedge clk);
        while (!axi_arready && n < 100) begin @(negedge clk); n++; end
        if (!axi_arready) fail_timeout("ar_timeout");
        @(posedge clk); #1;
        axi_arvalid = 1'b0;
    endtask

    task automatic push_model(input logic [31:0] addr, input int nbeats);
        logic [11:0] idx;
        rexp_t e;
        idx = addr[13:2];
        for (int i = 0; i < nbeats; i++) begin
            e.data = model[idx];
            e.last = (i == nbeats - 1);
            sb.push_back(e);
            idx = idx + 12'd1;
        end
    endtask

    task automatic w_burst(input logic [31:0] addr, input int nbeats,
                           input logic [31:0] base, input logic [3:0] strb);
        logic [11:0] idx;
        int n;
        idx = addr[13:2];
        for (int i = 0; i < nbeats; i++) begin
            axi_wdata = base + 32'(i); axi_wstrb = strb;
            axi_wlast = (i == nbeats - 1); axi_wvalid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!axi_wready && n < 100) begin @(negedge clk); n++; end
            if (!axi_wready) fail_timeout("w_timeout");
            @(posedge clk); #1;
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[idx][8*b +: 8] = axi_wdata[8*b +: 8];
            idx = idx + 12'd1;
        end
        axi_wvalid = 1'b0; axi_wlast = 1'b0;
    endtask

    task automatic b_check(input logic [0:0] id, output int waits);
        int n;
        n = 0;
        axi_bready = 1'b1;
        @(negedge clk);
        while (!axi_bvalid && n < 100) begin @(negedge clk); n++; end
        waits = n;
        if (!axi_bvalid) fail_timeout("b_timeout");
        else begin
            check("bresp", 32'(axi_bresp), 32'd0);
            check("bid", 32'(axi_bid), 32'(id));
        end
        @(posedge clk); #1;
        axi_bready = 1'b0;
    endtask

    task automatic r_collect(input int nbeats, input bit stall);
        int got, cyc;
        bit held_v;
        logic [31:0] held;
        rexp_t e;
        got = 0; cyc = 0; held_v = 1'b0; held = '0;
        while (got < nbeats && cyc < 2000) begin
            axi_rready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            @(negedge clk);
            if (axi_rvalid) begin
                if (held_v) check("r_hold", axi_rdata, held);
                if (stall) check("arready_busy", 32'(axi_arready), 32'd0);
                if (axi_rready) begin
                    if (sb.size() == 0) fail_timeout("sb_empty");
                    else begin
                        e = sb.pop_front();
                        check("rdata", axi_rdata, e.data);
                        check("rlast", 32'(axi_rlast), 32'(e.last));
                        check("rid", 32'(axi_rid), 32'(exp_rid));
                        check("rresp", 32'(axi_rresp), 32'd0);
                    end
                    got++;
                    held_v = 1'b0;
                end else begin
                    held_v = 1'b1;
                    held = axi_rdata;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        axi_rready = 1'b0;
        if (got < nbeats) fail_timeout("r_timeout");
        @(negedge clk);
        check("arready_after", 32'(axi_arready), 32'd1);
        check("rvalid_after", 32'(axi_rvalid), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t  vecs[5];
        rexp_t e;
        int    waits;

        vecs[0] = '{addr: 32'h20,   wdata: 32'hFFFFFFFF, wstrb: 4'hF, exp: 32'hFFFFFFFF};
        vecs[1] = '{addr: 32'h20,   wdata: 32'h00001200, wstrb: 4'h2, exp: 32'hFFFF12FF};
        vecs[2] = '{addr: 32'h24,   wdata: 32'h12345678, wstrb: 4'hF, exp: 32'h12345678};
        vecs[3] = '{addr: 32'h24,   wdata: 32'hAABBCCDD, wstrb: 4'h9, exp: 32'hAA3456DD};
        vecs[4] = '{addr: 32'h4024, wdata: 32'h00000000, wstrb: 4'h1, exp: 32'hAA345600};
        for (int i = 0; i < 4096; i++) model[i] = '0;

        // Reset values while rst is held low
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", 32'(axi_awready), 32'd1);
        check("rst_arready", 32'(axi_arready), 32'd1);
        check("rst_wready", 32'(axi_wready), 32'd0);
        check("rst_bvalid", 32'(axi_bvalid), 32'd0);
        check("rst_rvalid", 32'(axi_rvalid), 32'd0);
        check("rst_rlast", 32'(axi_rlast), 32'd0);
        check("rst_rdata", axi_rdata, 32'd0);
        check("rst_ids", 32'({axi_rid, axi_bid}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // W offered before any AW is stalled
        axi_wvalid = 1'b1; axi_wdata = 32'hDEADBEEF; axi_wstrb = 4'hF;
        repeat (2) begin
            @(negedge clk);
            check("w_before_aw", 32'(axi_wready), 32'd0);
        end
        @(posedge clk); #1;
        axi_wvalid = 1'b0;

        // Four-beat write then read of the same line
        aw_xfer(1'b1, 32'h10, 8'd3);
        w_burst(32'h10, 4, 32'hA, 4'hF);
        b_check(1'b1, waits);
        for (int i = 0; i < 4; i++) begin
            e.data = 32'hA + 32'(i);
            e.last = (i == 3);
            sb.push_back(e);
        end
        ar_xfer(1'b1, 32'h10, 8'd3);
        r_collect(4, 1'b0);

        // Single-beat byte-strobe vectors
        for (int v = 0; v < 5; v++) begin
            aw_xfer(1'b0, vecs[v].addr, 8'd0);
            w_burst(vecs[v].addr, 1, vecs[v].wdata, vecs[v].wstrb);
            b_check(1'b0, waits);
            check("b_latency", 32'(waits), 32'd0);
            e.data = vecs[v].exp; e.last = 1'b1;
            sb.push_back(e);
            ar_xfer(1'b0, vecs[v].addr, 8'd0);
            r_collect(1, 1'b0);
        end

        // Eight-beat read with rready stalls
        aw_xfer(1'b1, 32'h40, 8'd7);
        w_burst(32'h40, 8, 32'h100, 4'hF);
        b_check(1'b1, waits);
        push_model(32'h40, 8);
        ar_xfer(1'b0, 32'h40, 8'd7);
        r_collect(8, 1'b1);

        // Burst from the last word wraps to index 0
        aw_xfer(1'b0, 32'h3FFC, 8'd1);
        w_burst(32'h3FFC, 2, 32'h5A5A0000, 4'hF);
        b_check(1'b0, waits);
        e.data = 32'h5A5A0001; e.last = 1'b1;
        sb.push_back(e);
        ar_xfer(1'b1, 32'h0, 8'd0);
        r_collect(1, 1'b0);
        e.data = 32'h5A5A0000; e.last = 1'b0; sb.push_back(e);
        e.data = 32'h5A5A0001; e.last = 1'b1; sb.push_back(e);
        ar_xfer(1'b1, 32'h3FFC, 8'd1);
        r_collect(2, 1'b0);

        // Same-cycle AW and AR to one word: read sees the old value
        aw_xfer(1'b0, 32'h80, 8'd0);
        w_burst(32'h80, 1, 32'h11111111, 4'hF);
        b_check(1'b0, waits);
        e.data = 32'h11111111; e.last = 1'b1;
        sb.push_back(e);
        exp_rid = 1'b1;
        axi_awid = 1'b0; axi_awaddr = 32'h80; axi_awlen = 8'd0; axi_awvalid = 1'b1;
        axi_arid = 1'b1; axi_araddr = 32'h80; axi_arlen = 8'd0; axi_arvalid = 1'b1;
        @(negedge clk);
        check("collide_ready", 32'({axi_awready, axi_arready}), 32'd3);
        @(posedge clk); #1;
        axi_awvalid = 1'b0; axi_arvalid = 1'b0;
        w_burst(32'h80, 1, 32'h22222222, 4'hF);
        b_check(1'b0, waits);
        r_collect(1, 1'b0);
        e.data = 32'h22222222; e.last = 1'b1;
        sb.push_back(e);
        ar_xfer(1'b0, 32'h80, 8'd0);
        r_collect(1, 1'b0);

        // Full 256-beat burst exercises counter wrap
        aw_xfer(1'b1, 32'h800, 8'd255);
        w_burst(32'h800, 256, 32'hC0DE0000, 4'hF);
        b_check(1'b1, waits);
        push_model(32'h800, 256);
        ar_xfer(1'b1, 32'h800, 8'd255);
        r_collect(256, 1'b0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no end of test, expected finish");
        $fatal(1, "global timeout");
    end

endmodule
